// File: rtl/ram_port_arbiter_if.sv
// Bundle of requester handshakes (m0 = core LSU, m1 = DMA/debug loader) and
// the single RAM read/write port they share. The arbiter takes the slave
// view; the requesters and memory model take the master view.
interface ram_port_arbiter_if;
    // m0 requester
    logic        m0_req_i;
    logic        m0_we_i;
    logic [31:0] m0_addr_i;
    logic [31:0] m0_wdata_i;
    logic [3:0]  m0_be_i;
    logic        m0_gnt_o;
    logic        m0_ack_o;
    logic [31:0] m0_rdata_o;
    // m1 requester
    logic        m1_req_i;
    logic        m1_we_i;
    logic [31:0] m1_addr_i;
    logic [31:0] m1_wdata_i;
    logic [3:0]  m1_be_i;
    logic        m1_gnt_o;
    logic        m1_ack_o;
    logic [31:0] m1_rdata_o;
    // RAM port
    logic        ram_wr_en_o;
    logic [31:0] ram_wr_addr_o;
    logic [31:0] ram_wr_data_o;
    logic        ram_rd_en_o;
    logic [31:0] ram_rd_addr_o;
    logic [31:0] ram_rd_data_i;

    modport slave (
        input  m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i, m0_be_i,
        output m0_gnt_o, m0_ack_o, m0_rdata_o,
        input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_be_i,
        output m1_gnt_o, m1_ack_o, m1_rdata_o,
        output ram_wr_en_o, ram_wr_addr_o, ram_wr_data_o,
        output ram_rd_en_o, ram_rd_addr_o,
        input  ram_rd_data_i
    );

    modport master (
        output m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i, m0_be_i,
        input  m0_gnt_o, m0_ack_o, m0_rdata_o,
        output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_be_i,
        input  m1_gnt_o, m1_ack_o, m1_rdata_o,
        input  ram_wr_en_o, ram_wr_addr_o, ram_wr_data_o,
        input  ram_rd_en_o, ram_rd_addr_o,
        output ram_rd_data_i
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter for the single word-wide RAM port. One transaction is
// in flight at a time. Sub-word stores become a read-modify-write: the old
// word is read in the grant cycle and the merged word written in MERGE.
module ram_port_arbiter #(
    parameter int unsigned RAM_AW     = 21,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    ram_port_arbiter_if.slave  bus
);

    // Keeps RAM_AW low bits, drops the byte offset so every access is a word.
    localparam logic [31:0] ADDR_MASK =
        ((RAM_AW >= 32) ? 32'hFFFF_FFFF : ((32'h1 << RAM_AW) - 32'h1)) & 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MERGE = 2'd1,
        ACK   = 2'd2
    } state_e;

    state_e      state_q,    state_d;
    logic        last_gnt_q, last_gnt_d;   // id of the last requester granted
    logic        win_q,      win_d;        // id of the transaction in flight
    logic        we_q,       we_d;
    logic [31:0] aaddr_q,    aaddr_d;
    logic [31:0] wdata_q,    wdata_d;
    logic [3:0]  be_q,       be_d;
    logic [31:0] rdata_q,    rdata_d;

    // Winner selection and payload mux for the grant cycle
    logic        any_req;
    logic        win_sel;
    logic        sel_we;
    logic [31:0] sel_aaddr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_be;

    // Pick the winner among current requests and mux its payload
    always_comb begin
        any_req = bus.m0_req_i | bus.m1_req_i;
        if (bus.m0_req_i && bus.m1_req_i) begin
            win_sel = FIXED_PRIO ? 1'b0 : ~last_gnt_q;
        end else begin
            win_sel = bus.m1_req_i;
        end
        sel_we    = win_sel ? bus.m1_we_i    : bus.m0_we_i;
        sel_aaddr = (win_sel ? bus.m1_addr_i : bus.m0_addr_i) & ADDR_MASK;
        sel_wdata = win_sel ? bus.m1_wdata_i : bus.m0_wdata_i;
        sel_be    = win_sel ? bus.m1_be_i    : bus.m0_be_i;
    end

    // Next-state, datapath capture and all outputs
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        win_d      = win_q;
        we_d       = we_q;
        aaddr_d    = aaddr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        rdata_d    = rdata_q;

        bus.m0_gnt_o      = 1'b0;
        bus.m0_ack_o      = 1'b0;
        bus.m0_rdata_o    = 32'h0;
        bus.m1_gnt_o      = 1'b0;
        bus.m1_ack_o      = 1'b0;
        bus.m1_rdata_o    = 32'h0;
        bus.ram_wr_en_o   = 1'b0;
        bus.ram_wr_addr_o = 32'h0;
        bus.ram_wr_data_o = 32'h0;
        bus.ram_rd_en_o   = 1'b0;
        bus.ram_rd_addr_o = 32'h0;

        // While reset is held every output stays idle, so an interrupted
        // transaction can neither write the RAM nor acknowledge.
        if (!rst_i) begin
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        bus.m0_gnt_o = ~win_sel;
                        bus.m1_gnt_o =  win_sel;
                        win_d      = win_sel;
                        last_gnt_d = win_sel;
                        we_d       = sel_we;
                        aaddr_d    = sel_aaddr;
                        wdata_d    = sel_wdata;
                        be_d       = sel_be;
                        if (!sel_we) begin
                            bus.ram_rd_en_o   = 1'b1;
                            bus.ram_rd_addr_o = sel_aaddr;
                            rdata_d = bus.ram_rd_data_i;
                            state_d = ACK;
                        end else if (sel_be == 4'hF) begin
                            bus.ram_wr_en_o   = 1'b1;
                            bus.ram_wr_addr_o = sel_aaddr;
                            bus.ram_wr_data_o = sel_wdata;
                            state_d = ACK;
                        end else if (sel_be != 4'h0) begin
                            // Fetch the old word; lanes not enabled are kept.
                            bus.ram_rd_en_o   = 1'b1;
                            bus.ram_rd_addr_o = sel_aaddr;
                            rdata_d = bus.ram_rd_data_i;
                            state_d = MERGE;
                        end else begin
                            // Empty byte mask: acknowledge without touching RAM.
                            state_d = ACK;
                        end
                    end
                end

                MERGE: begin
                    bus.ram_wr_en_o   = 1'b1;
                    bus.ram_wr_addr_o = aaddr_q;
                    for (int k = 0; k < 4; k++) begin
                        bus.ram_wr_data_o[8*k +: 8] =
                            be_q[k] ? wdata_q[8*k +: 8] : rdata_q[8*k +: 8];
                    end
                    state_d = ACK;
                end

                ACK: begin
                    if (win_q) begin
                        bus.m1_ack_o   = 1'b1;
                        bus.m1_rdata_o = we_q ? 32'h0 : rdata_q;
                    end else begin
                        bus.m0_ack_o   = 1'b1;
                        bus.m0_rdata_o = we_q ? 32'h0 : rdata_q;
                    end
                    state_d = IDLE;
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and latched-transaction registers with synchronous reset
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments make every register sample the values
        // from before this edge, independent of statement order.
        if (rst_i) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            win_q      <= 1'b0;
            we_q       <= 1'b0;
            aaddr_q    <= 32'h0;
            wdata_q    <= 32'h0;
            be_q       <= 4'h0;
            rdata_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            win_q      <= win_d;
            we_q       <= we_d;
            aaddr_q    <= aaddr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            rdata_q    <= rdata_d;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: one round-robin instance backed by a
// small word memory, one fixed-priority instance backed by an address echo.
module tb_ram_port_arbiter;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    ram_port_arbiter_if bus ();
    ram_port_arbiter_if bus_f ();

    ram_port_arbiter #(.RAM_AW(21), .FIXED_PRIO(1'b0)) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    ram_port_arbiter #(.RAM_AW(21), .FIXED_PRIO(1'b1)) u_fix (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_f.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory: combinational read, write on the rising edge
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (bus.ram_wr_en_o) mem[bus.ram_wr_addr_o[9:2]] <= bus.ram_wr_data_o;
    end
    assign bus.ram_rd_data_i   = mem[bus.ram_rd_addr_o[9:2]];
    assign bus_f.ram_rd_data_i = {bus_f.ram_rd_addr_o[15:0], 16'hC0DE};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic m0_drive(input logic req, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be);
        bus.m0_req_i = req; bus.m0_we_i = we; bus.m0_addr_i = addr;
        bus.m0_wdata_i = wdata; bus.m0_be_i = be;
    endtask

    task automatic m1_drive(input logic req, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be);
        bus.m1_req_i = req; bus.m1_we_i = we; bus.m1_addr_i = addr;
        bus.m1_wdata_i = wdata; bus.m1_be_i = be;
    endtask

    initial begin
        logic [7:0] e_g0, e_g1, e_a0, e_a1;

        rst = 1'b1;
        m0_drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        m1_drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        bus_f.m0_req_i = 1'b0; bus_f.m0_we_i = 1'b0; bus_f.m0_addr_i = 32'h0;
        bus_f.m0_wdata_i = 32'h0; bus_f.m0_be_i = 4'h0;
        bus_f.m1_req_i = 1'b0; bus_f.m1_we_i = 1'b0; bus_f.m1_addr_i = 32'h0;
        bus_f.m1_wdata_i = 32'h0; bus_f.m1_be_i = 4'h0;
        tick();

        // Reset held with a request present: everything idle
        m0_drive(1'b1, 1'b1, 32'h0020_0010, 32'hDEAD_BEEF, 4'hF);
        sample();
        check("rst_gnt", {31'h0, bus.m0_gnt_o}, 32'h0);
        check("rst_wr_en", {31'h0, bus.ram_wr_en_o}, 32'h0);
        check("rst_wr_addr", bus.ram_wr_addr_o, 32'h0);
        tick();
        rst = 1'b0;

        // m0 full write
        sample();
        check("fw_gnt", {31'h0, bus.m0_gnt_o}, 32'h1);
        check("fw_m1_gnt", {31'h0, bus.m1_gnt_o}, 32'h0);
        check("fw_wr_en", {31'h0, bus.ram_wr_en_o}, 32'h1);
        check("fw_wr_addr", bus.ram_wr_addr_o, 32'h0000_0010);
        check("fw_wr_data", bus.ram_wr_data_o, 32'hDEAD_BEEF);
        tick();
        m0_drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        sample();
        check("fw_ack", {31'h0, bus.m0_ack_o}, 32'h1);
        check("fw_ack_gnt", {31'h0, bus.m0_gnt_o}, 32'h0);
        check("fw_ack_rdata", bus.m0_rdata_o, 32'h0);
        check("fw_ack_wr_en", {31'h0, bus.ram_wr_en_o}, 32'h0);
        tick();

        // m1 full write to a second word
        m1_drive(1'b1, 1'b1, 32'h0000_0014, 32'h1234_5678, 4'hF);
        sample();
        check("m1w_gnt", {31'h0, bus.m1_gnt_o}, 32'h1);
        check("m1w_m0_gnt", {31'h0, bus.m0_gnt_o}, 32'h0);
        tick();
        m1_drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        sample();
        check("m1w_ack", {31'h0, bus.m1_ack_o}, 32'h1);
        tick();

        // m0 read back
        m0_drive(1'b1, 1'b0, 32'h0020_0010, 32'h0, 4'h0);
        sample();
        check("rd_gnt", {31'h0, bus.m0_gnt_o}, 32'h1);
        check("rd_rd_en", {31'h0, bus.ram_rd_en_o}, 32'h1);
        check("rd_rd_addr", bus.ram_rd_addr_o, 32'h0000_0010);
        tick();
        m0_drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        sample();
        check("rd_ack", {31'h0, bus.m0_ack_o}, 32'h1);
        check("rd_rdata", bus.m0_rdata_o, 32'hDEAD_BEEF);
        tick();
        sample();
        check("idle_rdata", bus.m0_rdata_o, 32'h0);
        tick();

        // m0 partial write of the top byte
        m0_drive(1'b1, 1'b1, 32'h0020_0013, 32'h5A00_0000, 4'b1000);
        sample();
        check("pw_gnt", {31'h0, bus.m0_gnt_o}, 32'h1);
        check("pw_rd_en", {31'h0, bus.ram_rd_en_o}, 32'h1);
        check("pw_rd_addr", bus.ram_rd_addr_o, 32'h0000_0010);
        check("pw_t_wr_en", {31'h0, bus.ram_wr_en_o}, 32'h0);
        tick();
        m0_drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        sample();
        check("pw_wr_en", {31'h0, bus.ram_wr_en_o}, 32'h1);
        check("pw_wr_addr", bus.ram_wr_addr_o, 32'h0000_0010);
        check("pw_wr_data", bus.ram_wr_data_o, 32'h5AAD_BEEF);
        check("pw_merge_ack", {31'h0, bus.m0_ack_o}, 32'h0);
        tick();
        sample();
        check("pw_ack", {31'h0, bus.m0_ack_o}, 32'h1);
        check("pw_ack_wr_en", {31'h0, bus.ram_wr_en_o}, 32'h0);
        tick();
        m0_drive(1'b1, 1'b0, 32'h0020_0010, 32'h0, 4'h0);
        tick();
        m0_drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        sample();
        check("pw_rd_rdata", bus.m0_rdata_o, 32'h5AAD_BEEF);
        tick();

        // Reset, then both read together: m0 first, then strict alternation
        rst = 1'b1;
        m0_drive(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0);
        m1_drive(1'b1, 1'b0, 32'h0000_0014, 32'h0, 4'h0);
        tick();
        rst = 1'b0;
        e_g0 = 8'b0001_0001;  // bit c = expected value in cycle c
        e_a0 = 8'b0010_0010;
        e_g1 = 8'b0100_0100;
        e_a1 = 8'b1000_1000;
        for (int c = 0; c < 8; c++) begin
            sample();
            check($sformatf("rr_m0_gnt_c%0d", c), {31'h0, bus.m0_gnt_o}, {31'h0, e_g0[c]});
            check($sformatf("rr_m1_gnt_c%0d", c), {31'h0, bus.m1_gnt_o}, {31'h0, e_g1[c]});
            check($sformatf("rr_m0_ack_c%0d", c), {31'h0, bus.m0_ack_o}, {31'h0, e_a0[c]});
            check($sformatf("rr_m1_ack_c%0d", c), {31'h0, bus.m1_ack_o}, {31'h0, e_a1[c]});
            if (e_a0[c]) check($sformatf("rr_m0_rdata_c%0d", c), bus.m0_rdata_o, 32'h5AAD_BEEF);
            if (e_a1[c]) check($sformatf("rr_m1_rdata_c%0d", c), bus.m1_rdata_o, 32'h1234_5678);
            tick();
        end
        m0_drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        m1_drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();

        // Reset during MERGE of a low-byte write: no write, no ack
        m0_drive(1'b1, 1'b1, 32'h0020_0010, 32'h0000_00FF, 4'b0001);
        sample();
        check("rm_gnt", {31'h0, bus.m0_gnt_o}, 32'h1);
        check("rm_rd_en", {31'h0, bus.ram_rd_en_o}, 32'h1);
        tick();
        m0_drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        rst = 1'b1;
        sample();
        check("rm_wr_en", {31'h0, bus.ram_wr_en_o}, 32'h0);
        check("rm_ack", {31'h0, bus.m0_ack_o}, 32'h0);
        tick();
        rst = 1'b0;
        sample();
        check("rm_post_wr_en", {31'h0, bus.ram_wr_en_o}, 32'h0);
        check("rm_post_ack", {31'h0, bus.m0_ack_o}, 32'h0);
        tick();
        m0_drive(1'b1, 1'b0, 32'h0020_0010, 32'h0, 4'h0);
        tick();
        m0_drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        sample();
        check("rm_rd_ack", {31'h0, bus.m0_ack_o}, 32'h1);
        check("rm_rd_rdata", bus.m0_rdata_o, 32'h5AAD_BEEF);
        tick();

        // Empty byte mask: grant and ack, no RAM access
        m1_drive(1'b1, 1'b1, 32'h0000_0014, 32'hFFFF_FFFF, 4'h0);
        sample();
        check("be0_gnt", {31'h0, bus.m1_gnt_o}, 32'h1);
        check("be0_rd_en", {31'h0, bus.ram_rd_en_o}, 32'h0);
        check("be0_wr_en", {31'h0, bus.ram_wr_en_o}, 32'h0);
        tick();
        m1_drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        sample();
        check("be0_ack", {31'h0, bus.m1_ack_o}, 32'h1);
        check("be0_rdata", bus.m1_rdata_o, 32'h0);
        check("be0_ack_wr_en", {31'h0, bus.ram_wr_en_o}, 32'h0);
        tick();
        m1_drive(1'b1, 1'b0, 32'h0000_0014, 32'h0, 4'h0);
        tick();
        m1_drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        sample();
        check("be0_rd_rdata", bus.m1_rdata_o, 32'h1234_5678);
        tick();

        // Fixed priority: m0 always wins while it requests
        bus_f.m0_req_i = 1'b1; bus_f.m0_addr_i = 32'h0020_0010;
        bus_f.m1_req_i = 1'b1; bus_f.m1_addr_i = 32'h0000_0014;
        for (int c = 0; c < 8; c++) begin
            sample();
            check($sformatf("fp_m0_gnt_c%0d", c), {31'h0, bus_f.m0_gnt_o}, (c % 2 == 0) ? 32'h1 : 32'h0);
            check($sformatf("fp_m1_gnt_c%0d", c), {31'h0, bus_f.m1_gnt_o}, 32'h0);
            if (c % 2 == 1) check($sformatf("fp_m0_rdata_c%0d", c), bus_f.m0_rdata_o, 32'h0010_C0DE);
            tick();
        end
        bus_f.m0_req_i = 1'b0;
        sample();
        check("fp_m1_gnt_late", {31'h0, bus_f.m1_gnt_o}, 32'h1);
        tick();
        bus_f.m1_req_i = 1'b0;
        sample();
        check("fp_m1_ack", {31'h0, bus_f.m1_ack_o}, 32'h1);
        check("fp_m1_rdata", bus_f.m1_rdata_o, 32'h0014_C0DE);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
Shares the single RAM read/write port of the memory model between two requesters: m0 (core load/store unit) and m1 (DMA/debug loader).
The RAM port only writes whole words. The arbiter therefore turns sub-word stores (byte-enable not 4'hF) into a read-modify-write sequence.
It sits between the requesters and the memory's ram_* ports and has one transaction in flight at a time.

Parameters:
RAM_AW, 21, number of low address bits forwarded to the RAM. Upper bits are forced to 0 and bits [1:0] are forced to 0 (word aligned).
FIXED_PRIO, 0, 0 = round-robin between m0 and m1; 1 = m0 always wins.

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous active-high reset
m0_req_i  in  1  m0 request, held until m0_gnt_o seen
m0_we_i  in  1  1 = write, 0 = read
m0_addr_i  in  32  byte address
m0_wdata_i  in  32  write data, lane-aligned (byte k in bits [8k+7:8k])
m0_be_i  in  4  byte enables for writes; ignored for reads
m0_gnt_o  out  1  one-cycle pulse; payload is sampled in this cycle
m0_ack_o  out  1  one-cycle completion pulse
m0_rdata_o  out  32  read word, valid only with m0_ack_o, else 0
m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_be_i, m1_gnt_o, m1_ack_o, m1_rdata_o  same as m0 ports, for m1
ram_wr_en_o  out  1  to memory ram_wr_en_i
ram_wr_addr_o  out  32  to memory ram_wr_addr_i
ram_wr_data_o  out  32  to memory ram_wr_data_i
ram_rd_en_o  out  1  to memory ram_rd_en_i
ram_rd_addr_o  out  32  to memory ram_rd_addr_i
ram_rd_data_i  in  32  from memory; combinational, valid in the same cycle as rd_en/addr

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - state goes to IDLE; last_gnt := 1, so m0 wins the first tie.
  - All gnt, ack, ram_wr_en_o and ram_rd_en_o are 0. All rdata outputs and address/data outputs are 0.
  - Reset mid-transaction aborts it: no ack is issued and no RAM write occurs in the reset cycle or afterwards.
- Aligned address: aaddr = {zeros, addr[RAM_AW-1:2], 2'b00}.
- States: IDLE, MERGE, ACK.
- IDLE, no requests: all outputs idle.
- IDLE, one or more requests present:
  - Select the winner. With both requesting and FIXED_PRIO=0, grant the requester that is not last_gnt. With FIXED_PRIO=1, m0 wins.
  - Assert the winner's gnt, latch the payload and the winner id, and set last_gnt := winner.
  - Read (we=0): ram_rd_en_o=1, ram_rd_addr_o=aaddr; capture ram_rd_data_i into rdata_q; go to ACK.
  - Full write (be=4'hF): ram_wr_en_o=1, ram_wr_addr_o=aaddr, ram_wr_data_o=wdata; go to ACK.
  - Partial write (be not 4'hF and not 0): ram_rd_en_o=1 at aaddr; capture the old word into rdata_q; go to MERGE.
  - be=0 write: no RAM access; go to ACK (no-op).
- MERGE:
  - ram_wr_en_o=1 at the latched aaddr.
  - Data per byte k: wdata byte k if be[k]=1, else rdata_q byte k. Go to ACK.
  - Requests are not granted.
- ACK:
  - Winner's ack=1. Winner's rdata = rdata_q for a read, 0 for a write. Go to IDLE. No grant in this cycle.
- Latency (grant cycle = T):
  - read: ack at T+1.
  - full write: RAM write at T, ack at T+1.
  - partial write: RAM read at T, write at T+1, ack at T+2.
  - Next grant earliest at ack+1.
- The loser's request stays pending with no gnt. It is served the next IDLE cycle; no request is dropped.
- A requester that deasserts req before gnt is not served.
- Only the granted requester's gnt/ack ever pulse. gnt and ack are never high together.
- Ports not being driven in a cycle: ram_wr_en_o=0, ram_rd_en_o=0; addr/data outputs held at 0.

Test Plan:
- Reset, then m0 full write addr 0x0020_0010, data 0xDEADBEEF, be 4'hF -> gnt T, ram_wr_en_o=1 @0x0000_0010 at T, ack T+1. Then m0 read of the same address -> ack at +1 with rdata 0xDEADBEEF.
- m0 partial write addr 0x0020_0013, wdata 0x5A000000, be 4'b1000 over a stored 0xDEADBEEF -> read at T, write of 0x5AADBEEF at T+1, ack T+2. A following read returns 0x5AADBEEF.
- m0 and m1 request reads in the same cycle after reset -> m0 granted first. m1 granted the cycle after m0's ack. With both held, grants alternate m0, m1, m0, m1.
- FIXED_PRIO=1, both continuously requesting -> m1 is never granted while m0 requests.
- rst_i asserted in the MERGE cycle of a be=4'b0001 write -> no ram_wr_en_o, no ack. After reset, memory still holds the old word.
- be=0 write -> gnt, no ram_rd_en_o or ram_wr_en_o, ack at T+1 with rdata 0.
